// File: rtl/mesh_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mesh_pkg
// Description : Shared geometry constants and node slicing helper for the
//               26x18 toroidal mesh result path.
// Revision    : 1.0 - initial release
// ============================================================================
package mesh_pkg;

    localparam int MESH_COLS  = 26;
    localparam int MESH_ROWS  = 18;
    localparam int MESH_NODES = MESH_COLS * MESH_ROWS;
    localparam int NODE_OUT_W = 4;

    localparam int ROW_W = 5;
    localparam int COL_W = 5;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } ser_state_e;

    // Node 0 sits at the MSB end of the packed result bus.
    function automatic int node_slice_lsb(input int j);
        return NODE_OUT_W * (MESH_NODES - 1 - j);
    endfunction

endpackage
`default_nettype wire

// File: rtl/beat_coord_counter.sv
`default_nettype none
// ============================================================================
// Module      : beat_coord_counter
// Description : Beat index plus incremental row/column tracking for the
//               result serializer; no division anywhere.
// Revision    : 1.0 - initial release
// ============================================================================
module beat_coord_counter
    import mesh_pkg::*;
#(
    parameter int COLS           = MESH_COLS,
    parameter int NODES_PER_BEAT = 2,
    parameter int BEATS          = MESH_NODES / 2,
    parameter int K_W            = $clog2(BEATS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_step,
    output logic [K_W-1:0]   o_k,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_eol,
    output logic             o_last
);

    localparam logic [COL_W-1:0] c_col_step = COL_W'(NODES_PER_BEAT);
    localparam logic [COL_W-1:0] c_col_wrap = COL_W'(COLS - NODES_PER_BEAT);
    localparam logic [K_W-1:0]   c_k_last   = K_W'(BEATS - 1);

    logic [K_W-1:0]   r_k;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_eol;

    // The last beat of a row starts NODES_PER_BEAT columns before the edge.
    assign w_eol = (r_col == c_col_wrap);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_k   <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (i_step) begin
            r_k <= r_k + K_W'(1);
            if (w_eol) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + c_col_step;
            end
        end
    end

    assign o_k    = r_k;
    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_eol  = w_eol;
    assign o_last = (r_k == c_k_last);

endmodule
`default_nettype wire

// File: rtl/mesh_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : mesh_result_serializer
// Description : Snapshots the wide mesh result bus on start and streams it
//               out NODES_PER_BEAT nodes per beat over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_result_serializer
    import mesh_pkg::*;
#(
    parameter int COLS           = MESH_COLS,
    parameter int ROWS           = MESH_ROWS,
    parameter int NODE_W         = NODE_OUT_W,
    parameter int NODES_PER_BEAT = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [COLS*ROWS*NODE_W-1:0]      res_in,
    input  logic                             start,
    output logic [NODE_W*NODES_PER_BEAT-1:0] m_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [ROW_W-1:0]                 m_row,
    output logic [COL_W-1:0]                 m_col,
    output logic                             m_eol,
    output logic                             m_last,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int c_nodes  = COLS * ROWS;
    localparam int c_beats  = c_nodes / NODES_PER_BEAT;
    localparam int c_beat_w = NODE_W * NODES_PER_BEAT;
    localparam int c_bus_w  = c_nodes * NODE_W;
    localparam int c_k_w    = $clog2(c_beats);
    localparam int c_idx_w  = $clog2(c_bus_w);

    generate
        if ((COLS % NODES_PER_BEAT) != 0) begin : g_bad_beat_split
            $error("NODES_PER_BEAT must divide COLS");
        end
    endgenerate

    ser_state_e           r_state;
    ser_state_e           w_state_nxt;
    logic [c_bus_w-1:0]   r_snap;
    logic                 r_done;
    logic                 r_err;

    logic                 w_valid;
    logic                 w_capture;
    logic                 w_clear;
    logic                 w_step;
    logic                 w_frame_end;
    logic [c_k_w-1:0]     w_k;
    logic [ROW_W-1:0]     w_row;
    logic [COL_W-1:0]     w_col;
    logic                 w_eol;
    logic                 w_last;
    logic [c_idx_w-1:0]   w_lsb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        w_capture   = 1'b0;
        w_clear     = 1'b0;
        w_step      = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_capture   = 1'b1;
                    w_clear     = 1'b1;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                w_valid = 1'b1;
                if (m_ready) begin
                    if (w_last) begin
                        w_frame_end = 1'b1;
                        w_clear     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Snapshot contents are don't-care outside a frame, so no reset here.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_snap <= res_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_frame_end;
            if (start && (r_state == S_STREAM)) begin
                r_err <= 1'b1;
            end
        end
    end

    beat_coord_counter #(
        .COLS           (COLS),
        .NODES_PER_BEAT (NODES_PER_BEAT),
        .BEATS          (c_beats),
        .K_W            (c_k_w)
    ) u_coord (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_step  (w_step),
        .o_k     (w_k),
        .o_row   (w_row),
        .o_col   (w_col),
        .o_eol   (w_eol),
        .o_last  (w_last)
    );

    // Beat 0 is the top slice of the bus; later beats walk toward the LSB.
    assign w_lsb   = c_idx_w'((c_beats - 1 - int'(w_k)) * c_beat_w);

    assign m_data  = w_valid ? r_snap[w_lsb +: c_beat_w] : '0;
    assign m_valid = w_valid;
    assign m_row   = w_row;
    assign m_col   = w_col;
    assign m_eol   = w_valid & w_eol;
    assign m_last  = w_valid & w_last;
    assign busy    = w_valid;
    assign done    = r_done;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mesh_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesh_result_serializer
// Description : Scoreboard bench for the mesh result serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesh_result_serializer;
    import mesh_pkg::*;

    localparam int c_beats = 234;

    typedef struct packed {
        logic [7:0] data;
        logic [4:0] row;
        logic [4:0] col;
        logic       eol;
        logic       last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [1871:0] res_in;
    logic          start;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready;
    logic [4:0]    m_row;
    logic [4:0]    m_col;
    logic          m_eol;
    logic          m_last;
    logic          busy;
    logic          done;
    logic          err;

    int errors = 0;
    int checks = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];

    mesh_result_serializer dut (
        .clk     (clk),
        .rst     (rst),
        .res_in  (res_in),
        .start   (start),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_row   (m_row),
        .m_col   (m_col),
        .m_eol   (m_eol),
        .m_last  (m_last),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic logic [1871:0] pattern_bus();
        logic [1871:0] b;
        b = '0;
        for (int j = 0; j < MESH_NODES; j++) begin
            b[node_slice_lsb(j) +: 4] = 4'(j);
        end
        return b;
    endfunction

    task automatic push_frame(input logic [1871:0] bus);
        beat_t e;
        for (int k = 0; k < c_beats; k++) begin
            e.data = {bus[node_slice_lsb(2*k) +: 4], bus[node_slice_lsb(2*k+1) +: 4]};
            e.row  = 5'((2*k) / 26);
            e.col  = 5'((2*k) % 26);
            e.eol  = (((2*k) % 26) + 2 == 26);
            e.last = (k == c_beats - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Walks the stream, recording accepted beats. mode 0: ready high,
    // 1: ready 1,0,0,1 repeating, 2: random. Returns #1 after the edge that
    // follows the final handshake, or right after stop_after handshakes.
    task automatic collect(input int mode, input int start_at, input int stop_after,
                           output int hs, output int unstable, output int timed_out);
        beat_t cur, held;
        bit    have_held;
        int    ph;
        bit    pulsed;
        hs = 0; unstable = 0; timed_out = 1; have_held = 0; ph = 0; pulsed = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (hs == stop_after) begin
                timed_out = 0;
                return;
            end
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
            if (!pulsed && hs == start_at && m_valid) begin
                start  = 1'b1;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
            if (m_valid) begin
                cur = '{m_data, m_row, m_col, m_eol, m_last};
                if (have_held && cur !== held) unstable++;
                if (m_ready) begin
                    obs_q.push_back(cur);
                    hs++;
                    have_held = 0;
                    if (m_last) begin
                        @(posedge clk); #1;
                        start = 1'b0;
                        timed_out = 0;
                        return;
                    end
                end else begin
                    held      = cur;
                    have_held = 1;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; m_ready = 1'b0; res_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_valid, m_data, m_row, m_col, m_eol, m_last} !== 21'd0) begin
            errors++;
            $display("FAIL reset_stream: got %h want 0", {m_valid, m_data, m_row, m_col, m_eol, m_last});
        end
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: got %b want 000", {busy, done, err});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_pattern();
        int hs, uns, to;
        beat_t o, e;
        res_in = pattern_bus();
        push_frame(res_in);
        pulse_start();
        checks++;
        if ({m_valid, busy} !== 2'b11) begin
            errors++;
            $display("FAIL start_latency: valid/busy got %b want 11", {m_valid, busy});
        end
        collect(0, -1, -1, hs, uns, to);
        checks++;
        if (to != 0 || hs != c_beats) begin
            errors++;
            $display("FAIL pattern_count: got %0d beats timeout=%0d want %0d", hs, to, c_beats);
        end
        checks++;
        if ({done, busy, m_valid} !== 3'b100) begin
            errors++;
            $display("FAIL done_cycle: done/busy/valid got %b want 100", {done, busy, m_valid});
        end
        if (obs_q.size() == c_beats) begin
            checks++;
            if (obs_q[0] !== beat_t'{8'h01, 5'd0, 5'd0, 1'b0, 1'b0}) begin
                errors++; $display("FAIL beat0: got %h want %h", obs_q[0], beat_t'{8'h01, 5'd0, 5'd0, 1'b0, 1'b0});
            end
            checks++;
            if (obs_q[12] !== beat_t'{8'h89, 5'd0, 5'd24, 1'b1, 1'b0}) begin
                errors++; $display("FAIL beat12: got %h want %h", obs_q[12], beat_t'{8'h89, 5'd0, 5'd24, 1'b1, 1'b0});
            end
            checks++;
            if (obs_q[13] !== beat_t'{8'hAB, 5'd1, 5'd0, 1'b0, 1'b0}) begin
                errors++; $display("FAIL beat13: got %h want %h", obs_q[13], beat_t'{8'hAB, 5'd1, 5'd0, 1'b0, 1'b0});
            end
            checks++;
            if (obs_q[233] !== beat_t'{8'h23, 5'd17, 5'd24, 1'b1, 1'b1}) begin
                errors++; $display("FAIL beat233: got %h want %h", obs_q[233], beat_t'{8'h23, 5'd17, 5'd24, 1'b1, 1'b1});
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({done, err} !== 2'b00) begin
            errors++;
            $display("FAIL done_width_err: done/err got %b want 00", {done, err});
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL pattern_beat: got %h want %h", o, e); end
        end
    endtask

    task automatic test_stall();
        int hs, uns, to;
        beat_t o, e;
        res_in = pattern_bus();
        push_frame(res_in);
        pulse_start();
        collect(1, -1, -1, hs, uns, to);
        checks++;
        if (to != 0 || hs != c_beats || uns != 0) begin
            errors++;
            $display("FAIL stall_frame: beats=%0d unstable=%0d timeout=%0d want %0d/0/0", hs, uns, to, c_beats);
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL stall_beat: got %h want %h", o, e); end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_snapshot();
        int hs, uns, to;
        beat_t o, e;
        for (int i = 0; i < 1872 / 32; i++) res_in[i*32 +: 32] = $urandom;
        push_frame(res_in);
        pulse_start();
        res_in = '1;
        collect(2, -1, -1, hs, uns, to);
        checks++;
        if (to != 0 || hs != c_beats || uns != 0) begin
            errors++;
            $display("FAIL snapshot_frame: beats=%0d unstable=%0d timeout=%0d", hs, uns, to);
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL snapshot_beat: got %h want %h", o, e); end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_err_restart();
        int hs, uns, to;
        beat_t o, e;
        res_in = pattern_bus();
        push_frame(res_in);
        pulse_start();
        collect(0, 50, -1, hs, uns, to);
        checks++;
        if (to != 0 || hs != c_beats || {done, err} !== 2'b11) begin
            errors++;
            $display("FAIL err_frame: beats=%0d done/err=%b want %0d/11", hs, {done, err}, c_beats);
        end
        res_in = ~pattern_bus();
        push_frame(res_in);
        pulse_start();
        checks++;
        if ({m_valid, m_row, m_col} !== 11'b1_00000_00000) begin
            errors++;
            $display("FAIL restart_in_done: valid/row/col got %b", {m_valid, m_row, m_col});
        end
        collect(0, -1, -1, hs, uns, to);
        checks++;
        if (to != 0 || hs != c_beats || err !== 1'b1) begin
            errors++;
            $display("FAIL restart_frame: beats=%0d err=%b want %0d/1", hs, err, c_beats);
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL err_beat: got %h want %h", o, e); end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int hs, uns, to;
        int done_seen;
        beat_t o, e;
        res_in = pattern_bus();
        pulse_start();
        collect(0, -1, 100, hs, uns, to);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({m_valid, busy, done, err, m_row, m_col, m_eol, m_last} !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid: got %b want 0", {m_valid, busy, done, err, m_row, m_col, m_eol, m_last});
        end
        done_seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done || m_valid) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d active cycles want 0", done_seen);
        end
        obs_q.delete();
        exp_q.delete();
        push_frame(res_in);
        pulse_start();
        collect(0, -1, -1, hs, uns, to);
        checks++;
        if (to != 0 || hs != c_beats) begin
            errors++;
            $display("FAIL after_reset_frame: beats=%0d want %0d", hs, c_beats);
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL after_reset_beat: got %h want %h", o, e); end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_all_ones();
        int hs, uns, to;
        int eols, bad;
        beat_t o;
        res_in = '1;
        pulse_start();
        collect(0, -1, -1, hs, uns, to);
        eols = 0; bad = 0;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (o.eol) eols++;
            if (o.data !== 8'hFF) bad++;
        end
        checks++;
        if (to != 0 || hs != c_beats) begin
            errors++;
            $display("FAIL ones_count: got %0d handshakes want %0d", hs, c_beats);
        end
        checks++;
        if (eols != 18) begin
            errors++;
            $display("FAIL ones_eol: got %0d want 18", eols);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ones_data: got %0d non-FF beats want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_stall();
        test_snapshot();
        test_err_restart();
        test_reset_mid();
        test_all_ones();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
